clint_timer: RTL and testbench

// - Core-local interruptor at clint_base_addr..clint_top_addr (0x2000000..0x200C000).
// - Owns msip, mtimecmp and the free-running 64-bit mtime; drives the machine software/timer interrupt lines.
// - Slave on the core data-memory bus; selected by the bus decode when the address falls in the CLINT window.
// - Also exports mtime for the time/timeh CSRs.

---
 rtl/clint_timer.sv | 148 ++++++++++++++
 tb/tb_clint_timer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// ---------------------------------------------------------------------------
// clint_timer
// Core-local interruptor. Holds the msip bit, the 64-bit mtimecmp compare
// value and the free-running 64-bit mtime counter, and raises the machine
// software / timer interrupt lines. Sits on the core data-memory bus as a
// single-cycle-latency slave and also exports mtime for the time CSRs.
//
// Parameters
//   clint_base_addr : base byte address of the register window
//   clk_divider     : clock cycles per mtime tick (>= 1)
//
// Ports
//   reset        in   1   asynchronous, active-low reset
//   clock        in   1   core clock, rising edge
//   clint_valid  in   1   request strobe, one cycle per request
//   clint_instr  in   1   request is an instruction fetch (never serviced)
//   clint_addr   in  32   byte address, word aligned
//   clint_wdata  in  32   write data
//   clint_wstrb  in   4   byte enables, 4'b0000 means read
//   clint_rdata  out 32   read data, zero whenever clint_ready is low
//   clint_ready  out  1   one-cycle response strobe, one cycle after request
//   clint_msip   out  1   machine software interrupt pending
//   clint_mtip   out  1   machine timer interrupt pending
//   clint_mtime  out 64   current mtime
// ---------------------------------------------------------------------------
module clint_timer #(
  parameter logic [31:0] clint_base_addr = 32'h0200_0000,
  parameter int unsigned clk_divider     = 1
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  localparam logic [31:0] off_msip       = 32'h0000_0000;
  localparam logic [31:0] off_mtimecmp_l = 32'h0000_4000;
  localparam logic [31:0] off_mtimecmp_h = 32'h0000_4004;
  localparam logic [31:0] off_mtime_l    = 32'h0000_BFF8;
  localparam logic [31:0] off_mtime_h    = 32'h0000_BFFC;

  // A divider of 1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int unsigned presc_w = (clk_divider > 1) ? $clog2(clk_divider) : 1;
  localparam logic [presc_w-1:0] presc_max = presc_w'(clk_divider - 1);

  logic               msip_q, msip_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [presc_w-1:0] presc_q, presc_d;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mtip_q, mtip_d;

  logic [31:0] offset;
  logic        is_wr;
  logic        is_rd;
  logic        tick;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    offset = clint_addr - clint_base_addr;
    // Instruction fetches get a response but never touch or expose state.
    is_wr  = clint_valid && !clint_instr && (clint_wstrb != 4'b0000);
    is_rd  = clint_valid && !clint_instr && (clint_wstrb == 4'b0000);

    tick    = (presc_q == presc_max);
    presc_d = tick ? '0 : presc_q + presc_w'(1);

    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

    // A write to either mtime half overrides that cycle's tick entirely:
    // the other half holds, so no carry can leak across.
    if (is_wr) begin
      case (offset)
        off_msip:       if (clint_wstrb[0]) msip_d = clint_wdata[0];
        off_mtimecmp_l: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  clint_wdata, clint_wstrb);
        off_mtimecmp_h: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
        off_mtime_l:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], clint_wdata, clint_wstrb)};
        off_mtime_h:    mtime_d = {merge_bytes(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};
        default:        ;
      endcase
    end

    // Reads return the pre-update register contents of the request cycle.
    rdata_d = '0;
    if (is_rd) begin
      case (offset)
        off_msip:       rdata_d = {31'b0, msip_q};
        off_mtimecmp_l: rdata_d = mtimecmp_q[31:0];
        off_mtimecmp_h: rdata_d = mtimecmp_q[63:32];
        off_mtime_l:    rdata_d = mtime_q[31:0];
        off_mtime_h:    rdata_d = mtime_q[63:32];
        default:        rdata_d = '0;
      endcase
    end

    ready_d = clint_valid;
    // Compare the current registers so mtip trails the register state by one cycle.
    mtip_d  = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q    <= 64'd0;
      presc_q    <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      mtip_q     <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      mtip_q     <= mtip_d;
    end
  end

  assign clint_rdata = rdata_q;
  assign clint_ready = ready_q;
  assign clint_msip  = msip_q;
  assign clint_mtip  = mtip_q;
  assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// ---------------------------------------------------------------------------
// tb_clint_timer
// Drives two clint_timer instances (divider 1 and divider 4) from one shared
// bus and compares every output against a register-level model on each
// falling edge. Directed sequences pin a few literal values, then a random
// phase exercises the whole register map.
// ---------------------------------------------------------------------------
module tb_clint_timer;

  localparam logic [31:0] base = 32'h0200_0000;

  logic        clock;
  logic        reset;
  logic        clint_valid;
  logic        clint_instr;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;

  logic [1:0]       ready_o;
  logic [1:0]       msip_o;
  logic [1:0]       mtip_o;
  logic [1:0][31:0] rdata_o;
  logic [1:0][63:0] mtime_o;

  int checks;
  int failures;

  // Model state: register contents plus the expected registered outputs.
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic        m_msip  [2];
  logic [31:0] m_rdata [2];
  logic        m_mtip  [2];
  logic        m_ready;
  longint      m_cyc;

  logic [31:0] offs [9];

  clint_timer #(.clint_base_addr(base), .clk_divider(1)) u_dut0 (
    .reset(reset), .clock(clock), .clint_valid(clint_valid), .clint_instr(clint_instr),
    .clint_addr(clint_addr), .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb),
    .clint_rdata(rdata_o[0]), .clint_ready(ready_o[0]), .clint_msip(msip_o[0]),
    .clint_mtip(mtip_o[0]), .clint_mtime(mtime_o[0])
  );

  clint_timer #(.clint_base_addr(base), .clk_divider(4)) u_dut1 (
    .reset(reset), .clock(clock), .clint_valid(clint_valid), .clint_instr(clint_instr),
    .clint_addr(clint_addr), .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb),
    .clint_rdata(rdata_o[1]), .clint_ready(ready_o[1]), .clint_msip(msip_o[1]),
    .clint_mtip(mtip_o[1]), .clint_mtime(mtime_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    if (s[0]) r[7:0]   = n[7:0];
    if (s[1]) r[15:8]  = n[15:8];
    if (s[2]) r[23:16] = n[23:16];
    if (s[3]) r[31:24] = n[31:24];
    return r;
  endfunction

  function automatic logic bus_write();
    return clint_valid && !clint_instr && (clint_wstrb != 4'b0000);
  endfunction

  function automatic logic bus_read();
    return clint_valid && !clint_instr && (clint_wstrb == 4'b0000);
  endfunction

  function automatic logic [63:0] next_mtime(input int i);
    logic [31:0] off;
    off = clint_addr - base;
    if (bus_write() && off == 32'hBFF8)
      return {m_mtime[i][63:32], mrg(m_mtime[i][31:0], clint_wdata, clint_wstrb)};
    if (bus_write() && off == 32'hBFFC)
      return {mrg(m_mtime[i][63:32], clint_wdata, clint_wstrb), m_mtime[i][31:0]};
    if (((m_cyc + 1) % div_of(i)) == 0) return m_mtime[i] + 64'd1;
    return m_mtime[i];
  endfunction

  function automatic logic [63:0] next_cmp(input int i);
    logic [31:0] off;
    off = clint_addr - base;
    if (bus_write() && off == 32'h4000)
      return {m_cmp[i][63:32], mrg(m_cmp[i][31:0], clint_wdata, clint_wstrb)};
    if (bus_write() && off == 32'h4004)
      return {mrg(m_cmp[i][63:32], clint_wdata, clint_wstrb), m_cmp[i][31:0]};
    return m_cmp[i];
  endfunction

  function automatic logic next_msip(input int i);
    if (bus_write() && (clint_addr - base) == 32'h0 && clint_wstrb[0]) return clint_wdata[0];
    return m_msip[i];
  endfunction

  function automatic logic [31:0] read_val(input int i);
    logic [31:0] off;
    off = clint_addr - base;
    if (!bus_read()) return 32'd0;
    case (off)
      32'h0000: return {31'd0, m_msip[i]};
      32'h4000: return m_cmp[i][31:0];
      32'h4004: return m_cmp[i][63:32];
      32'hBFF8: return m_mtime[i][31:0];
      32'hBFFC: return m_mtime[i][63:32];
      default:  return 32'd0;
    endcase
  endfunction

  // Reference model, advanced on every rising edge from the sampled bus.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ready <= 1'b0;
      m_cyc   <= 0;
      for (int i = 0; i < 2; i++) begin
        m_mtime[i] <= 64'd0;
        m_cmp[i]   <= 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[i]  <= 1'b0;
        m_rdata[i] <= 32'd0;
        m_mtip[i]  <= 1'b0;
      end
    end else begin
      m_ready <= clint_valid;
      m_cyc   <= m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
        m_rdata[i] <= read_val(i);
        m_mtip[i]  <= (m_mtime[i] >= m_cmp[i]);
        m_mtime[i] <= next_mtime(i);
        m_cmp[i]   <= next_cmp(i);
        m_msip[i]  <= next_msip(i);
      end
    end
  end

  task automatic check_output(input string name, input int inst,
                              input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s inst=%0d got=%h exp=%h", name, inst, got, exp);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      check_output("ready", i, {63'd0, ready_o[i]}, {63'd0, m_ready});
      check_output("rdata", i, {32'd0, rdata_o[i]}, {32'd0, m_rdata[i]});
      check_output("msip",  i, {63'd0, msip_o[i]},  {63'd0, m_msip[i]});
      check_output("mtip",  i, {63'd0, mtip_o[i]},  {63'd0, m_mtip[i]});
      check_output("mtime", i, mtime_o[i], m_mtime[i]);
    end
  end

  // Drive one bus cycle from a falling edge and wait for the next falling edge.
  task automatic apply_stimulus(input logic v, input logic instr, input logic [31:0] off,
                                input logic [31:0] wd, input logic [3:0] st);
    clint_valid = v;
    clint_instr = instr;
    clint_addr  = base + off;
    clint_wdata = wd;
    clint_wstrb = st;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    int          n;
    int unsigned r;
    logic        v;
    logic        ins;
    logic [3:0]  st;
    logic [31:0] wd;

    checks   = 0;
    failures = 0;
    offs     = '{32'h0, 32'h4, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC,
                 32'h1000, 32'hC000, 32'hFE00_0000};
    reset       = 1'b0;
    clint_valid = 1'b0;
    clint_instr = 1'b0;
    clint_addr  = base;
    clint_wdata = 32'h0;
    clint_wstrb = 4'h0;

    repeat (3) @(negedge clock);
    #2 reset = 1'b1;

    // Idle after reset: mtime counts the cycles, nothing else moves.
    repeat (10) @(negedge clock);
    check_output("pin_idle_mtime", 0, mtime_o[0], 64'd10);
    check_output("pin_idle_ready", 0, {63'd0, ready_o[0]}, 64'd0);
    check_output("pin_idle_mtip",  0, {63'd0, mtip_o[0]}, 64'd0);
    check_output("pin_idle_msip",  0, {63'd0, msip_o[0]}, 64'd0);

    // msip set, read back, clear.
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h1, 4'hF);
    check_output("pin_msip_set", 0, {63'd0, msip_o[0]}, 64'd1);
    check_output("pin_wr_ready", 0, {63'd0, ready_o[0]}, 64'd1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    check_output("pin_msip_rd", 0, {32'd0, rdata_o[0]}, 64'd1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    check_output("pin_msip_clr", 0, {63'd0, msip_o[0]}, 64'd0);

    // mtimecmp = 20: mtip follows mtime reaching 20 by one cycle.
    apply_stimulus(1'b1, 1'b0, 32'h4004, 32'd0, 4'hF);
    apply_stimulus(1'b1, 1'b0, 32'h4000, 32'd20, 4'hF);
    idle(1);
    n = 0;
    while (mtime_o[0] != 64'd20 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_output("pin_wait_mtime20", 0, {63'd0, (n < 50)}, 64'd1);
    check_output("pin_mtip_pre", 0, {63'd0, mtip_o[0]}, 64'd0);
    idle(1);
    check_output("pin_mtip_rise", 0, {63'd0, mtip_o[0]}, 64'd1);
    apply_stimulus(1'b1, 1'b0, 32'h4000, 32'd1000, 4'hF);
    idle(1);
    check_output("pin_mtip_clr", 0, {63'd0, mtip_o[0]}, 64'd0);

    // Carry from the low half, then full 64-bit wrap.
    apply_stimulus(1'b1, 1'b0, 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    apply_stimulus(1'b1, 1'b0, 32'hBFFC, 32'h0, 4'hF);
    check_output("pin_mtime_lo_ones", 0, mtime_o[0], 64'h0000_0000_FFFF_FFFF);
    idle(1);
    check_output("pin_mtime_carry", 0, mtime_o[0], 64'h0000_0001_0000_0000);
    apply_stimulus(1'b1, 1'b0, 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    apply_stimulus(1'b1, 1'b0, 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    check_output("pin_mtime_ones", 0, mtime_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    check_output("pin_mtime_wrap", 0, mtime_o[0], 64'd0);

    // Byte-lane write to mtime, then divider behaviour.
    apply_stimulus(1'b1, 1'b0, 32'hBFF8, 32'h1234_5678, 4'hF);
    apply_stimulus(1'b1, 1'b0, 32'hBFFC, 32'h0, 4'hF);
    apply_stimulus(1'b1, 1'b0, 32'hBFF8, 32'h0000_00AB, 4'b0001);
    check_output("pin_byte_wr", 0, mtime_o[0], 64'h1234_56AB);
    check_output("pin_byte_wr", 1, mtime_o[1], 64'h1234_56AB);
    idle(4);
    check_output("pin_div1_4cyc", 0, mtime_o[0], 64'h1234_56AF);
    check_output("pin_div4_4cyc", 1, mtime_o[1], 64'h1234_56AC);

    // Unmapped read, instruction fetch, back-to-back reads.
    apply_stimulus(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    check_output("pin_unmapped_rd", 0, {32'd0, rdata_o[0]}, 64'd0);
    check_output("pin_unmapped_rdy", 0, {63'd0, ready_o[0]}, 64'd1);
    apply_stimulus(1'b1, 1'b1, 32'h4000, 32'h0, 4'h0);
    check_output("pin_fetch_rd", 0, {32'd0, rdata_o[0]}, 64'd0);
    apply_stimulus(1'b1, 1'b1, 32'h0, 32'h1, 4'hF);
    check_output("pin_fetch_wr", 0, {63'd0, msip_o[0]}, 64'd0);
    apply_stimulus(1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
    check_output("pin_cmp_rd", 0, {32'd0, rdata_o[0]}, 64'd1000);
    apply_stimulus(1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
    apply_stimulus(1'b1, 1'b0, 32'h4004, 32'h0, 4'h0);
    idle(2);

    // Reset in the middle of a request: the request is dropped.
    clint_valid = 1'b1;
    clint_addr  = base;
    clint_wstrb = 4'h0;
    #2 reset = 1'b0;
    @(negedge clock);
    check_output("pin_rst_ready", 0, {63'd0, ready_o[0]}, 64'd0);
    clint_valid = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_output("pin_rst_mtime", 0, mtime_o[0], 64'd3);
    check_output("pin_rst_mtime", 1, mtime_o[1], 64'd0);

    // Randomised traffic over the whole map.
    for (int k = 0; k < 400; k++) begin
      r   = $urandom_range(0, 8);
      v   = ($urandom_range(0, 9) < 6);
      ins = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      wd  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      apply_stimulus(v, ins, offs[r], wd, st);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
